// File: rtl/rs_age_scheduler_if.sv
// Issue, result-broadcast and dispatch bundle for the ALU reservation station.
// The slave modport is the scheduler itself; the master modport is its
// environment (issue unit, CDB and ALU side).
interface rs_age_scheduler_if #(
  parameter int DEPTH = 16,
  parameter int NCDB  = 2,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32,
  parameter int OP_W  = 6,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic                  rdy;
  logic                  flush;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [OP_W-1:0]       issue_opcode;
  logic [XLEN-1:0]       issue_val1;
  logic [XLEN-1:0]       issue_val2;
  logic [TAG_W-1:0]      issue_dep1;
  logic [TAG_W-1:0]      issue_dep2;
  logic                  issue_has_dep1;
  logic                  issue_has_dep2;
  logic [TAG_W-1:0]      issue_rob_index;
  logic [XLEN-1:0]       issue_imm;
  logic [XLEN-1:0]       issue_pc;
  logic [NCDB-1:0]       cdb_valid;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic [NCDB*XLEN-1:0]  cdb_data;
  logic                  disp_valid;
  logic                  disp_ready;
  logic [OP_W-1:0]       disp_opcode;
  logic [XLEN-1:0]       disp_val1;
  logic [XLEN-1:0]       disp_val2;
  logic [XLEN-1:0]       disp_imm;
  logic [XLEN-1:0]       disp_pc;
  logic [TAG_W-1:0]      disp_rob_index;
  logic [CNT_W-1:0]      count;
  logic                  full;

  modport master (
    output rdy, flush, issue_valid, issue_opcode, issue_val1, issue_val2,
           issue_dep1, issue_dep2, issue_has_dep1, issue_has_dep2,
           issue_rob_index, issue_imm, issue_pc, cdb_valid, cdb_tag, cdb_data,
           disp_ready,
    input  issue_ready, disp_valid, disp_opcode, disp_val1, disp_val2,
           disp_imm, disp_pc, disp_rob_index, count, full
  );

  modport slave (
    input  rdy, flush, issue_valid, issue_opcode, issue_val1, issue_val2,
           issue_dep1, issue_dep2, issue_has_dep1, issue_has_dep2,
           issue_rob_index, issue_imm, issue_pc, cdb_valid, cdb_tag, cdb_data,
           disp_ready,
    output issue_ready, disp_valid, disp_opcode, disp_val1, disp_val2,
           disp_imm, disp_pc, disp_rob_index, count, full
  );
endinterface

// File: rtl/rs_age_scheduler.sv
// Age-ordered reservation station for the ALU issue path. Entries capture
// operands from the result broadcast channels at issue time and while waiting;
// the oldest fully-ready entry is moved into a dispatch register each cycle
// the ALU side can take it.
module rs_age_scheduler #(
  parameter int DEPTH = 16,
  parameter int NCDB  = 2,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32,
  parameter int OP_W  = 6,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic                clk,
  input logic                rst,
  rs_age_scheduler_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {hit, data}; the lowest-numbered matching valid channel wins.
  function automatic logic [XLEN:0] cdb_match(
    input logic [TAG_W-1:0]      tag,
    input logic [NCDB-1:0]       valid,
    input logic [NCDB*TAG_W-1:0] tags,
    input logic [NCDB*XLEN-1:0]  data
  );
    logic [XLEN:0] res;
    res = '0;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (valid[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, data[k*XLEN +: XLEN]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Entry storage
  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] hd1_r;
  logic [DEPTH-1:0] hd2_r;
  logic [OP_W-1:0]  opcode_r [DEPTH];
  logic [XLEN-1:0]  val1_r   [DEPTH];
  logic [XLEN-1:0]  val2_r   [DEPTH];
  logic [TAG_W-1:0] dep1_r   [DEPTH];
  logic [TAG_W-1:0] dep2_r   [DEPTH];
  logic [TAG_W-1:0] rob_r    [DEPTH];
  logic [XLEN-1:0]  imm_r    [DEPTH];
  logic [XLEN-1:0]  pc_r     [DEPTH];
  // older_r[i][j] = 1: entry i was written before entry j
  logic [DEPTH-1:0] older_r  [DEPTH];

  // Dispatch register and bookkeeping
  logic             disp_valid_r;
  logic [OP_W-1:0]  disp_opcode_r;
  logic [XLEN-1:0]  disp_val1_r;
  logic [XLEN-1:0]  disp_val2_r;
  logic [XLEN-1:0]  disp_imm_r;
  logic [XLEN-1:0]  disp_pc_r;
  logic [TAG_W-1:0] disp_rob_r;
  logic [CNT_W-1:0] count_r;
  logic             full_r;
  logic             issue_ready_r;

  // Combinational helpers
  logic [DEPTH-1:0] ready_s;
  logic [DEPTH-1:0] older_t_s [DEPTH];
  logic [DEPTH-1:0] grant_s;
  logic             any_ready_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic [IDX_W-1:0] free_idx_s;
  logic             accept_s;
  logic             load_s;
  logic [CNT_W-1:0] count_next_s;
  logic [XLEN:0]    wake1_s [DEPTH];
  logic [XLEN:0]    wake2_s [DEPTH];
  logic [XLEN:0]    byp1_s;
  logic [XLEN:0]    byp2_s;

  assign ready_s     = busy_r & ~hd1_r & ~hd2_r;
  assign any_ready_s = |ready_s;
  assign accept_s    = bus.issue_valid && issue_ready_r && !bus.flush;
  assign load_s      = (!disp_valid_r || bus.disp_ready) && any_ready_s && !bus.flush;

  // Age select: a ready entry wins when no other ready entry is older than it.
  always_comb begin
    grant_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_t_s[i][j] = older_r[j][i];
      end
      grant_s[i] = ready_s[i] & ~(|(ready_s & older_t_s[i]));
    end
  end

  // Encode the granted entry and the lowest free slot.
  always_comb begin
    sel_idx_s  = '0;
    free_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (grant_s[i]) begin
        sel_idx_s = IDX_W'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
      if (!busy_r[i]) begin
        free_idx_s = IDX_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  // Tag match of every waiting operand and the incoming issue against the CDB.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1_s[i] = cdb_match(dep1_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      wake2_s[i] = cdb_match(dep2_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
    byp1_s = cdb_match(bus.issue_dep1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    byp2_s = cdb_match(bus.issue_dep2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  // Occupancy update: issue and load in the same cycle cancel out.
  always_comb begin
    case ({accept_s, load_s})
      2'b10:   count_next_s = count_r + ONE_C;
      2'b01:   count_next_s = count_r - ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // Entry, age-matrix and dispatch-register state; everything holds while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r        <= '0;
      hd1_r         <= '0;
      hd2_r         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_r[i] <= '0;
        val1_r[i]   <= '0;
        val2_r[i]   <= '0;
        dep1_r[i]   <= '0;
        dep2_r[i]   <= '0;
        rob_r[i]    <= '0;
        imm_r[i]    <= '0;
        pc_r[i]     <= '0;
        older_r[i]  <= '0;
      end
      disp_valid_r  <= 1'b0;
      disp_opcode_r <= '0;
      disp_val1_r   <= '0;
      disp_val2_r   <= '0;
      disp_imm_r    <= '0;
      disp_pc_r     <= '0;
      disp_rob_r    <= '0;
      count_r       <= '0;
      full_r        <= 1'b0;
      issue_ready_r <= 1'b1;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        busy_r        <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          older_r[i] <= '0;
        end
        disp_valid_r  <= 1'b0;
        count_r       <= '0;
        full_r        <= 1'b0;
        issue_ready_r <= 1'b1;
      end else begin
        // Wakeup of waiting operands in busy entries
        for (int i = 0; i < DEPTH; i++) begin
          if (busy_r[i] && hd1_r[i] && wake1_s[i][XLEN]) begin
            val1_r[i] <= wake1_s[i][XLEN-1:0];
            hd1_r[i]  <= 1'b0;
          end
          if (busy_r[i] && hd2_r[i] && wake2_s[i][XLEN]) begin
            val2_r[i] <= wake2_s[i][XLEN-1:0];
            hd2_r[i]  <= 1'b0;
          end
        end
        // Move the oldest ready entry into the dispatch register
        if (load_s) begin
          busy_r[sel_idx_s] <= 1'b0;
          disp_opcode_r     <= opcode_r[sel_idx_s];
          disp_val1_r       <= val1_r[sel_idx_s];
          disp_val2_r       <= val2_r[sel_idx_s];
          disp_imm_r        <= imm_r[sel_idx_s];
          disp_pc_r         <= pc_r[sel_idx_s];
          disp_rob_r        <= rob_r[sel_idx_s];
        end
        if (!disp_valid_r || bus.disp_ready) begin
          disp_valid_r <= any_ready_s;
        end
        // Write a new entry into the lowest free slot (free at the registered state)
        if (accept_s) begin
          busy_r[free_idx_s]   <= 1'b1;
          opcode_r[free_idx_s] <= bus.issue_opcode;
          dep1_r[free_idx_s]   <= bus.issue_dep1;
          dep2_r[free_idx_s]   <= bus.issue_dep2;
          rob_r[free_idx_s]    <= bus.issue_rob_index;
          imm_r[free_idx_s]    <= bus.issue_imm;
          pc_r[free_idx_s]     <= bus.issue_pc;
          hd1_r[free_idx_s]    <= bus.issue_has_dep1 && !byp1_s[XLEN];
          hd2_r[free_idx_s]    <= bus.issue_has_dep2 && !byp2_s[XLEN];
          val1_r[free_idx_s]   <= (bus.issue_has_dep1 && byp1_s[XLEN]) ? byp1_s[XLEN-1:0] : bus.issue_val1;
          val2_r[free_idx_s]   <= (bus.issue_has_dep2 && byp2_s[XLEN]) ? byp2_s[XLEN-1:0] : bus.issue_val2;
          older_r[free_idx_s]  <= '0;
          for (int x = 0; x < DEPTH; x++) begin
            older_r[x][free_idx_s] <= busy_r[x];
          end
        end
        count_r       <= count_next_s;
        full_r        <= (count_next_s == DEPTH_C);
        issue_ready_r <= (count_next_s != DEPTH_C);
      end
    end
  end

  assign bus.issue_ready    = issue_ready_r;
  assign bus.disp_valid     = disp_valid_r;
  assign bus.disp_opcode    = disp_opcode_r;
  assign bus.disp_val1      = disp_val1_r;
  assign bus.disp_val2      = disp_val2_r;
  assign bus.disp_imm       = disp_imm_r;
  assign bus.disp_pc        = disp_pc_r;
  assign bus.disp_rob_index = disp_rob_r;
  assign bus.count          = count_r;
  assign bus.full           = full_r;
endmodule

// File: tb/tb_rs_age_scheduler.sv
// Directed bench for rs_age_scheduler: expected dispatches are queued when
// instructions are issued and checked against every handshake transfer.
module tb_rs_age_scheduler;
  localparam int DEPTH = 16;
  localparam int NCDB  = 2;
  localparam int TAG_W = 6;
  localparam int XLEN  = 32;
  localparam int OP_W  = 6;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PKT_W = OP_W + TAG_W + 4 * XLEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [PKT_W-1:0] sb [$];

  rs_age_scheduler_if #(.DEPTH(DEPTH), .NCDB(NCDB), .TAG_W(TAG_W), .XLEN(XLEN),
                        .OP_W(OP_W), .CNT_W(CNT_W)) bus ();

  rs_age_scheduler #(.DEPTH(DEPTH), .NCDB(NCDB), .TAG_W(TAG_W), .XLEN(XLEN),
                     .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Per-instruction side fields derived from the ROB index
  function automatic logic [OP_W-1:0] op_of(input logic [TAG_W-1:0] r);
    return r ^ 6'h2a;
  endfunction
  function automatic logic [PKT_W-1:0] mk(input logic [TAG_W-1:0] r,
                                          input logic [XLEN-1:0] v1,
                                          input logic [XLEN-1:0] v2);
    return {op_of(r), r, v1, v2, {26'd0, r} << 4, 32'h1000 + ({26'd0, r} << 2)};
  endfunction
  function automatic logic [PKT_W-1:0] got();
    return {bus.disp_opcode, bus.disp_rob_index, bus.disp_val1, bus.disp_val2,
            bus.disp_imm, bus.disp_pc};
  endfunction

  task automatic check(input string tag, input logic [PKT_W-1:0] obs,
                       input logic [PKT_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score a handshake transfer on the coming edge, then advance.
  task automatic step();
    logic [PKT_W-1:0] e;
    if (!rst && bus.rdy && bus.disp_valid && bus.disp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_disp", PKT_W'(bus.disp_valid), '0);
      end else begin
        e = sb.pop_front();
        check("disp_pkt", got(), e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [TAG_W-1:0] r, input logic [XLEN-1:0] v1,
                       input logic [XLEN-1:0] v2, input logic hd1,
                       input logic [TAG_W-1:0] d1);
    bus.issue_valid     = 1'b1;
    bus.issue_rob_index = r;
    bus.issue_opcode    = op_of(r);
    bus.issue_val1      = v1;
    bus.issue_val2      = v2;
    bus.issue_has_dep1  = hd1;
    bus.issue_dep1      = d1;
    bus.issue_has_dep2  = 1'b0;
    bus.issue_dep2      = '0;
    bus.issue_imm       = {26'd0, r} << 4;
    bus.issue_pc        = 32'h1000 + ({26'd0, r} << 2);
    step();
    bus.issue_valid     = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles && sb.size() > 0; c++) step();
    check("drain_left", PKT_W'(sb.size()), '0);
  endtask

  task automatic cdb(input logic [1:0] v, input logic [TAG_W-1:0] t1,
                     input logic [XLEN-1:0] d1, input logic [TAG_W-1:0] t0,
                     input logic [XLEN-1:0] d0);
    bus.cdb_valid = v;
    bus.cdb_tag   = {t1, t0};
    bus.cdb_data  = {d1, d0};
  endtask

  initial begin
    bus.rdy = 1'b1; bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.disp_ready = 1'b0;
    bus.issue_opcode = '0; bus.issue_val1 = '0; bus.issue_val2 = '0;
    bus.issue_dep1 = '0; bus.issue_dep2 = '0; bus.issue_has_dep1 = 1'b0;
    bus.issue_has_dep2 = 1'b0; bus.issue_rob_index = '0; bus.issue_imm = '0;
    bus.issue_pc = '0;
    cdb(2'b00, '0, '0, '0, '0);

    // Reset values
    rst = 1'b1; step(); step(); rst = 1'b0;
    check("rst_count", PKT_W'(bus.count), '0);
    check("rst_full", PKT_W'(bus.full), '0);
    check("rst_issue_ready", PKT_W'(bus.issue_ready), PKT_W'(1));
    check("rst_disp_valid", PKT_W'(bus.disp_valid), '0);
    check("rst_disp_pkt", got(), '0);

    // Three ready ops, dispatched in order one per cycle
    bus.disp_ready = 1'b1;
    for (int r = 1; r <= 3; r++) sb.push_back(mk(6'(r), 32'(r * 7), 32'(r * 11)));
    issue(6'd1, 32'd7, 32'd11, 1'b0, '0);
    check("lat_before", PKT_W'(bus.disp_valid), '0);
    issue(6'd2, 32'd14, 32'd22, 1'b0, '0);
    check("lat_first_valid", PKT_W'(bus.disp_valid), PKT_W'(1));
    check("lat_first_rob", PKT_W'(bus.disp_rob_index), PKT_W'(1));
    issue(6'd3, 32'd21, 32'd33, 1'b0, '0);
    check("b2b_rob", PKT_W'(bus.disp_rob_index), PKT_W'(2));
    drain(8);
    check("t1_count", PKT_W'(bus.count), '0);

    // Fill all entries waiting on tag 9, then a single broadcast
    bus.disp_ready = 1'b0;
    for (int r = 16; r < 32; r++) issue(6'(r), 32'd0, 32'(r), 1'b1, 6'd9);
    check("fill_count", PKT_W'(bus.count), PKT_W'(DEPTH));
    check("fill_full", PKT_W'(bus.full), PKT_W'(1));
    check("fill_issue_ready", PKT_W'(bus.issue_ready), '0);
    issue(6'd40, 32'd1, 32'd2, 1'b0, '0);
    check("full_reject_count", PKT_W'(bus.count), PKT_W'(DEPTH));
    for (int r = 16; r < 32; r++) sb.push_back(mk(6'(r), 32'hDEAD, 32'(r)));
    bus.disp_ready = 1'b1;
    cdb(2'b10, 6'd9, 32'hDEAD, 6'd9, 32'hBEEF);
    step();
    cdb(2'b00, '0, '0, '0, '0);
    check("bcast_count", PKT_W'(bus.count), PKT_W'(DEPTH));
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      check("drain_count", PKT_W'(bus.count), PKT_W'(DEPTH - i));
    end
    drain(4);

    // Issue-time bypass from channel 0
    sb.push_back(mk(6'd41, 32'h1234, 32'd5));
    cdb(2'b01, '0, '0, 6'd5, 32'h1234);
    issue(6'd41, 32'd0, 32'd5, 1'b1, 6'd5);
    cdb(2'b00, '0, '0, '0, '0);
    drain(6);

    // ALU stall, then rdy low during a pending handshake
    bus.disp_ready = 1'b0;
    sb.push_back(mk(6'd50, 32'd150, 32'd250));
    sb.push_back(mk(6'd51, 32'd153, 32'd255));
    issue(6'd50, 32'd150, 32'd250, 1'b0, '0);
    issue(6'd51, 32'd153, 32'd255, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pkt", got(), mk(6'd50, 32'd150, 32'd250));
      check("stall_count", PKT_W'(bus.count), PKT_W'(1));
    end
    bus.disp_ready = 1'b1;
    step();
    check("after_stall_rob", PKT_W'(bus.disp_rob_index), PKT_W'(51));
    bus.rdy = 1'b0;
    step(); step();
    check("rdy_low_valid", PKT_W'(bus.disp_valid), PKT_W'(1));
    check("rdy_low_pkt", got(), mk(6'd51, 32'd153, 32'd255));
    bus.rdy = 1'b1;
    drain(4);
    check("t4_count", PKT_W'(bus.count), '0);

    // Age across slot reuse: A, B (waits), C (waits, reuses A's slot)
    sb.push_back(mk(6'd60, 32'd60, 32'd0));
    issue(6'd60, 32'd60, 32'd0, 1'b0, '0);
    issue(6'd61, 32'd0, 32'd1, 1'b1, 6'd21);
    issue(6'd62, 32'd0, 32'd2, 1'b1, 6'd22);
    sb.push_back(mk(6'd61, 32'hB1B1, 32'd1));
    sb.push_back(mk(6'd62, 32'hC2C2, 32'd2));
    cdb(2'b11, 6'd22, 32'hC2C2, 6'd21, 32'hB1B1);
    step();
    cdb(2'b00, '0, '0, '0, '0);
    drain(6);

    // Flush with five waiting entries and a loaded dispatch register
    bus.disp_ready = 1'b0;
    issue(6'd70, 32'd1, 32'd1, 1'b0, '0);
    for (int r = 71; r < 76; r++) issue(6'(r), 32'd0, 32'd0, 1'b1, 6'd33);
    check("pre_flush_count", PKT_W'(bus.count), PKT_W'(5));
    check("pre_flush_valid", PKT_W'(bus.disp_valid), PKT_W'(1));
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_count", PKT_W'(bus.count), '0);
    check("flush_valid", PKT_W'(bus.disp_valid), '0);
    check("flush_issue_ready", PKT_W'(bus.issue_ready), PKT_W'(1));
    check("flush_full", PKT_W'(bus.full), '0);
    bus.disp_ready = 1'b1;
    cdb(2'b11, 6'd33, 32'h5555, 6'd33, 32'h4444);
    step();
    cdb(2'b00, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stale_valid", PKT_W'(bus.disp_valid), '0);
    end
    check("final_count", PKT_W'(bus.count), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
